// File: rtl/tpu_host_ctrl.sv
// Host-side TPU job sequencer: load A/B operand buffers, start the TPU, wait for busy, drain buffer C.
// Latency: cmd accept -> ld_ready next cycle; last B beat -> in_valid next cycle; busy fall -> first rd_valid 2 cycles later.
// Backpressure: ld_valid/ld_ready and rd_valid/rd_ready handshakes; cmd_ready only while idle; rd_data held while rd_ready is low.
//
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready, cmd_K/M/N   : job command (matrix dimensions)
//   ld_valid/ld_ready, ld_data       : operand stream, A words first then B words
//   rd_valid/rd_ready, rd_data       : result stream read back from buffer C
//   done, err                        : one-cycle job-complete / command-rejected pulses
//   in_valid, K, M, N, busy          : TPU start pulse, latched dimensions, TPU busy
//   A_*/B_*                          : global buffer A/B write ports
//   C_index, C_data_out              : global buffer C read port (data one cycle after index)
module tpu_host_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_K,
    input  logic [7:0]            cmd_M,
    input  logic [7:0]            cmd_N,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [DATA_BITS-1:0]  ld_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATAC_BITS-1:0] rd_data,
    output logic                  done,
    output logic                  err,
    output logic                  in_valid,
    output logic [7:0]            K,
    output logic [7:0]            M,
    output logic [7:0]            N,
    input  logic                  busy,
    output logic                  A_wr_en,
    output logic [ADDR_BITS-1:0]  A_index,
    output logic [DATA_BITS-1:0]  A_data_in,
    output logic                  B_wr_en,
    output logic [ADDR_BITS-1:0]  B_index,
    output logic [DATA_BITS-1:0]  B_data_in,
    output logic [ADDR_BITS-1:0]  C_index,
    input  logic [DATAC_BITS-1:0] C_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DRAIN_RD,
        S_DRAIN_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_BITS-1:0]    cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]    na_q, na_d;
    logic [ADDR_BITS-1:0]    nb_q, nb_d;
    logic [ADDR_BITS-1:0]    nc_q, nc_d;
    logic [7:0]              k_q, k_d;
    logic [7:0]              m_q, m_d;
    logic [7:0]              n_q, n_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [DATAC_BITS-1:0]   rd_data_q, rd_data_d;
    logic                    out_first_q, out_first_d;

    // Word counts from the command dimensions; ceil(x/4) packs 4 lanes per word.
    logic [ADDR_BITS-1:0]    m_words, n_words;
    logic [ADDR_BITS-1:0]    na_calc, nb_calc, nc_calc;
    logic                    dims_ok;
    logic                    cnt_last_a, cnt_last_b, cnt_last_c;
    logic                    a_wr, b_wr;

    assign m_words = (ADDR_BITS'(cmd_M) + ADDR_BITS'(3)) >> 2;
    assign n_words = (ADDR_BITS'(cmd_N) + ADDR_BITS'(3)) >> 2;
    assign na_calc = ADDR_BITS'(cmd_K) * m_words;
    assign nb_calc = ADDR_BITS'(cmd_K) * n_words;
    assign nc_calc = ADDR_BITS'(cmd_M) * n_words;
    assign dims_ok = (cmd_K != 8'd0) && (cmd_M != 8'd0) && (cmd_N != 8'd0);

    assign cnt_last_a = ((cnt_q + ADDR_BITS'(1)) == na_q);
    assign cnt_last_b = ((cnt_q + ADDR_BITS'(1)) == nb_q);
    assign cnt_last_c = ((cnt_q + ADDR_BITS'(1)) == nc_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        na_d        = na_q;
        nb_d        = nb_q;
        nc_d        = nc_q;
        k_d         = k_q;
        m_d         = m_q;
        n_d         = n_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rd_data_d   = rd_data_q;
        out_first_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (dims_ok) begin
                        k_d     = cmd_K;
                        m_d     = cmd_M;
                        n_d     = cmd_N;
                        na_d    = na_calc;
                        nb_d    = nb_calc;
                        nc_d    = nc_calc;
                        cnt_d   = '0;
                        state_d = S_LOAD_A;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD_A: begin
                if (ld_valid) begin
                    if (cnt_last_a) begin
                        cnt_d   = '0;
                        state_d = S_LOAD_B;
                    end else begin
                        cnt_d = cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            S_LOAD_B: begin
                if (ld_valid) begin
                    if (cnt_last_b) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + ADDR_BITS'(1);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN_RD;
                end
            end
            S_DRAIN_RD: begin
                out_first_d = 1'b1;
                state_d     = S_DRAIN_OUT;
            end
            S_DRAIN_OUT: begin
                // Buffer data for the address issued in DRAIN_RD lands now; keep it for stalls.
                if (out_first_q) begin
                    rd_data_d = C_data_out;
                end
                if (rd_ready) begin
                    cnt_d = cnt_q + ADDR_BITS'(1);
                    if (cnt_last_c) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            na_q        <= '0;
            nb_q        <= '0;
            nc_q        <= '0;
            k_q         <= '0;
            m_q         <= '0;
            n_q         <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_data_q   <= '0;
            out_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            na_q        <= na_d;
            nb_q        <= nb_d;
            nc_q        <= nc_d;
            k_q         <= k_d;
            m_q         <= m_d;
            n_q         <= n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_data_q   <= rd_data_d;
            out_first_q <= out_first_d;
        end
    end

    // Write strobes follow the accepted beat in the same cycle.
    assign a_wr      = (state_q == S_LOAD_A) && ld_valid;
    assign b_wr      = (state_q == S_LOAD_B) && ld_valid;

    assign cmd_ready = (state_q == S_IDLE);
    assign ld_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
    assign A_wr_en   = a_wr;
    assign A_index   = a_wr ? cnt_q : '0;
    assign A_data_in = a_wr ? ld_data : '0;
    assign B_wr_en   = b_wr;
    assign B_index   = b_wr ? cnt_q : '0;
    assign B_data_in = b_wr ? ld_data : '0;
    assign in_valid  = (state_q == S_START);
    assign K         = k_q;
    assign M         = m_q;
    assign N         = n_q;
    assign C_index   = ((state_q == S_DRAIN_RD) || (state_q == S_DRAIN_OUT)) ? cnt_q : '0;
    assign rd_valid  = (state_q == S_DRAIN_OUT);
    // First DRAIN_OUT cycle passes the buffer word straight through; later cycles use the held copy.
    assign rd_data   = (rd_valid && out_first_q) ? C_data_out : rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Bench for tpu_host_ctrl: random jobs against a cycle-level job model, plus directed cases.
// Latency: n/a.
// Backpressure: bench drives random ld_valid gaps and rd_ready stalls.
module tb_tpu_host_ctrl;
    localparam int AB = 16;
    localparam int DB = 32;
    localparam int CB = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [7:0]    cmd_K, cmd_M, cmd_N;
    logic          ld_valid, ld_ready;
    logic [DB-1:0] ld_data;
    logic          rd_valid, rd_ready;
    logic [CB-1:0] rd_data;
    logic          done, err, in_valid;
    logic [7:0]    K, M, N;
    logic          busy;
    logic          A_wr_en, B_wr_en;
    logic [AB-1:0] A_index, B_index, C_index;
    logic [DB-1:0] A_data_in, B_data_in;
    logic [CB-1:0] C_data_out;

    tpu_host_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .DATAC_BITS(CB)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_K(cmd_K), .cmd_M(cmd_M), .cmd_N(cmd_N),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err), .in_valid(in_valid),
        .K(K), .M(M), .N(N), .busy(busy),
        .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
        .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
        .C_index(C_index), .C_data_out(C_data_out)
    );

    always #5 clk = ~clk;

    // Buffer C: synchronous read, word appears the cycle after its index.
    logic [CB-1:0] cmem [0:1023];
    always @(posedge clk) C_data_out <= cmem[C_index[9:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int ceil4(input int x);
        return (x + 3) / 4;
    endfunction

    // Job model: what each cycle's outputs must be, derived from beat counts and cycle stamps.
    int         cyc;
    bit         act_q, seen_hi, drain;
    int         na, nb, nc, beats, reads;
    int         start_cyc, rd_cyc, done_cyc, err_cyc;
    logic [7:0] k_e, m_e, n_e;
    int         a_wr_cnt, b_wr_cnt, iv_cnt, hs_cnt, done_cnt, err_cnt;
    int         last_a_idx, last_c_idx;

    task automatic model_reset();
        act_q = 0; seen_hi = 0; drain = 0;
        na = 0; nb = 0; nc = 0; beats = 0; reads = 0;
        start_cyc = -1; rd_cyc = -1; done_cyc = -1; err_cyc = -1;
        k_e = 0; m_e = 0; n_e = 0;
    endtask

    task automatic monitor();
        bit e_ldr, acc, e_aw, e_bw, e_rv;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("rst_cmd_ready", cmd_ready, 1);
                chk("rst_ld_ready", ld_ready, 0);
                chk("rst_rd_valid", rd_valid, 0);
                chk("rst_rd_data", rd_data, 0);
                chk("rst_done", done, 0);
                chk("rst_err", err, 0);
                chk("rst_in_valid", in_valid, 0);
                chk("rst_KMN", {K, M, N}, 0);
                chk("rst_wr_en", {A_wr_en, B_wr_en}, 0);
                chk("rst_index", {A_index, B_index, C_index}, 0);
                chk("rst_wdata", {A_data_in, B_data_in}, 0);
                model_reset();
            end else begin
                e_ldr = act_q && (beats < na + nb);
                acc   = ld_valid && e_ldr;
                e_aw  = acc && (beats < na);
                e_bw  = acc && (beats >= na);
                e_rv  = drain && (cyc > rd_cyc);

                chk("cmd_ready", cmd_ready, !act_q);
                chk("ld_ready", ld_ready, e_ldr);
                chk("A_wr_en", A_wr_en, e_aw);
                chk("B_wr_en", B_wr_en, e_bw);
                if (e_aw) begin
                    chk("A_index", A_index, beats);
                    chk("A_data_in", A_data_in, ld_data);
                end
                if (e_bw) begin
                    chk("B_index", B_index, beats - na);
                    chk("B_data_in", B_data_in, ld_data);
                end
                chk("in_valid", in_valid, act_q && (cyc == start_cyc));
                chk("KMN", {K, M, N}, {k_e, m_e, n_e});
                chk("done", done, cyc == done_cyc);
                chk("err", err, cyc == err_cyc);
                chk("rd_valid", rd_valid, e_rv);
                if (e_rv) chk("rd_data", rd_data, cmem[reads]);
                if (drain && cyc == rd_cyc) begin
                    chk("C_index", C_index, reads);
                    last_c_idx = C_index;
                end

                if (A_wr_en) begin a_wr_cnt++; last_a_idx = A_index; end
                if (B_wr_en) b_wr_cnt++;
                if (in_valid) iv_cnt++;
                if (done) done_cnt++;
                if (err) err_cnt++;
                if (rd_valid && rd_ready) hs_cnt++;

                if (cmd_valid && !act_q) begin
                    if (cmd_K == 0 || cmd_M == 0 || cmd_N == 0) begin
                        err_cyc = cyc + 1;
                    end else begin
                        act_q = 1; seen_hi = 0; drain = 0;
                        k_e = cmd_K; m_e = cmd_M; n_e = cmd_N;
                        na = int'(cmd_K) * ceil4(int'(cmd_M));
                        nb = int'(cmd_K) * ceil4(int'(cmd_N));
                        nc = int'(cmd_M) * ceil4(int'(cmd_N));
                        beats = 0; reads = 0; start_cyc = -1;
                    end
                end
                if (acc) begin
                    beats++;
                    if (beats == na + nb) start_cyc = cyc + 1;
                end
                if (act_q && start_cyc >= 0 && cyc > start_cyc && !drain) begin
                    if (busy) seen_hi = 1;
                    else if (seen_hi) begin drain = 1; rd_cyc = cyc + 1; end
                end
                if (e_rv && rd_ready) begin
                    reads++;
                    if (reads == nc) begin
                        done_cyc = cyc + 1; act_q = 0; drain = 0;
                    end else begin
                        rd_cyc = cyc + 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int k, input int m, input int n);
        int w = 0;
        while (!cmd_ready && w < 200) begin tick(); w++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1; cmd_K = 8'(k); cmd_M = 8'(m); cmd_N = 8'(n);
        tick();
        cmd_valid = 0;
    endtask

    // mode 0: continuous, 1: 1-0-1-1-0-1 gaps, 2: random. abort_b>0 stops after that many B beats.
    task automatic load_ops(input int total, input int na_, input int mode, input int abort_b, input bit special);
        int sent = 0, budget = 0, ph = 0, target;
        bit v, accepted;
        logic [5:0] pat6 = 6'b101101;
        target = (abort_b > 0) ? na_ + abort_b : total;
        while (sent < target && budget < 2000) begin
            case (mode)
                0: v = 1;
                1: v = pat6[5 - (ph % 6)];
                default: v = 1'($urandom_range(0, 1));
            endcase
            ph++;
            ld_valid = v;
            ld_data  = (special && sent < na_) ? 32'h01010101 * (sent + 1) : $urandom;
            accepted = v && ld_ready;
            tick();
            budget++;
            if (accepted) sent++;
        end
        if (abort_b == 0) ld_valid = 0;
        chk("load_complete", sent == target, 1);
    endtask

    task automatic tpu_run(input bit early, input int d, input int h);
        int w = 0;
        if (early) busy = 1;
        while (!in_valid && w < 50) begin tick(); w++; end
        chk("in_valid_seen", in_valid, 1);
        if (!early) begin
            repeat (d) tick();
            busy = 1;
        end
        repeat (h) tick();
        busy = 0;
    endtask

    // mode 0: rd_ready always 1, 1: 1-0-0-1 pattern, 2: random.
    task automatic drain_out(input int mode);
        int w = 0, ph = 0;
        bit seen = 0;
        logic [3:0] pat4 = 4'b1001;
        while (w < 3000) begin
            case (mode)
                0: rd_ready = 1;
                1: rd_ready = pat4[3 - (ph % 4)];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
            tick();
            w++;
            if (done) begin seen = 1; break; end
        end
        rd_ready = 0;
        chk("done_seen", seen, 1);
    endtask

    task automatic job(input int k, input int m, input int n, input int lmode, input int rmode,
                       input bit early, input bit special, input int d, input int h);
        int na_, nb_;
        na_ = k * ceil4(m);
        nb_ = k * ceil4(n);
        send_cmd(k, m, n);
        load_ops(na_ + nb_, na_, lmode, 0, special);
        tpu_run(early, d, h);
        drain_out(rmode);
        tick();
    endtask

    int s_a, s_b, s_iv, s_hs, s_d, s_e;
    task automatic snap();
        s_a = a_wr_cnt; s_b = b_wr_cnt; s_iv = iv_cnt; s_hs = hs_cnt; s_d = done_cnt; s_e = err_cnt;
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_K = 0; cmd_M = 0; cmd_N = 0;
        ld_valid = 0; ld_data = 0; rd_ready = 0; busy = 0;
        for (int i = 0; i < 1024; i++) cmem[i] = {$urandom, $urandom, $urandom, $urandom};
        cyc = 0;
        a_wr_cnt = 0; b_wr_cnt = 0; iv_cnt = 0; hs_cnt = 0; done_cnt = 0; err_cnt = 0;
        last_a_idx = -1; last_c_idx = -1;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) tick();
        rst = 0;
        tick();

        // 4x4x4 with fixed A words, busy 2 cycles after start for 10 cycles.
        snap();
        job(4, 4, 4, 0, 0, 0, 1, 2, 10);
        chk("j4_a_writes", a_wr_cnt - s_a, 4);
        chk("j4_last_a_idx", last_a_idx, 3);
        chk("j4_b_writes", b_wr_cnt - s_b, 4);
        chk("j4_in_valid", iv_cnt - s_iv, 1);
        chk("j4_K", K, 4);
        chk("j4_words", hs_cnt - s_hs, 4);
        chk("j4_done", done_cnt - s_d, 1);

        // 5x5x5 with busy already high at START.
        snap();
        job(5, 5, 5, 0, 0, 1, 0, 1, 6);
        chk("j5_a_writes", a_wr_cnt - s_a, 10);
        chk("j5_last_a_idx", last_a_idx, 9);
        chk("j5_b_writes", b_wr_cnt - s_b, 10);
        chk("j5_words", hs_cnt - s_hs, 10);
        chk("j5_last_c_idx", last_c_idx, 9);

        // 8x8x8 with rd_ready stalls.
        snap();
        job(8, 8, 8, 0, 1, 0, 0, 3, 4);
        chk("j8_words", hs_cnt - s_hs, 16);
        chk("j8_done", done_cnt - s_d, 1);

        // Zero dimension is rejected.
        snap();
        send_cmd(4, 0, 4);
        repeat (4) tick();
        chk("m0_err", err_cnt - s_e, 1);
        chk("m0_writes", (a_wr_cnt - s_a) + (b_wr_cnt - s_b), 0);
        chk("m0_in_valid", iv_cnt - s_iv, 0);

        // Next job follows normally, with gapped operand stream.
        snap();
        job(3, 6, 7, 1, 2, 0, 0, 2, 3);
        chk("gap_a_writes", a_wr_cnt - s_a, 6);
        chk("gap_b_writes", b_wr_cnt - s_b, 6);
        chk("gap_words", hs_cnt - s_hs, 12);

        // Reset during LOAD_B after 3 B beats with a beat in flight.
        snap();
        send_cmd(4, 4, 4);
        load_ops(8, 4, 0, 3, 0);
        ld_valid = 1;
        rst = 1;
        repeat (2) tick();
        rst = 0;
        ld_valid = 0;
        tick();
        chk("rst_mid_b_writes", b_wr_cnt - s_b, 3);
        chk("rst_mid_done", done_cnt - s_d, 0);
        chk("rst_mid_in_valid", iv_cnt - s_iv, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);

        // Random jobs.
        for (int j = 0; j < 8; j++) begin
            job($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 9),
                $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0,
                $urandom_range(1, 4), $urandom_range(2, 12));
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
